// File: rtl/bk_adder_scheduler_pkg.sv
// Shared types and constants for the Brent-Kung adder scheduler.
// Optional double-width operation is enabled with BK_SCHED_WIDE_EN.
package bk_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    function automatic int ID_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bk_adder_scheduler_if.sv
// Request / adder / response bundle of the adder scheduler.
// BK_SCHED_WIDE_EN doubles operand width and adds req_wide.
interface bk_adder_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    localparam int IW = bk_sched_pkg::ID_W(NREQ);
`ifdef BK_SCHED_WIDE_EN
    localparam int OPW = 2 * WIDTH;
`else
    localparam int OPW = WIDTH;
`endif

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_a;
    logic [NREQ*OPW-1:0] req_b;
    logic [NREQ-1:0]     req_cin;
`ifdef BK_SCHED_WIDE_EN
    logic [NREQ-1:0]     req_wide;
`endif
    logic [WIDTH-1:0]    add_a;
    logic [WIDTH-1:0]    add_b;
    logic                add_cin;
    logic [WIDTH-1:0]    add_sum;
    logic [WIDTH-1:0]    add_c;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [OPW-1:0]      rsp_sum;
    logic                rsp_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, add_sum, add_c, rsp_ready,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef BK_SCHED_WIDE_EN
        , input req_wide
`endif
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, add_sum, add_c, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout
`ifdef BK_SCHED_WIDE_EN
        , output req_wide
`endif
    );

endinterface

// File: rtl/bk_adder_scheduler_arb.sv
// Combinational round-robin arbiter: first valid bit at or after i_ptr,
// searched cyclically; one-hot grant plus encoded index.
module bk_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_id,
    output logic            o_any
);

    int            w_pos;
    logic [IW-1:0] w_idx;

    // Scan farthest-first so the candidate nearest the pointer overwrites the rest.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NREQ) w_pos = w_pos - NREQ;
            w_idx = IW'(w_pos);
            if (i_valid[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_id           = w_idx;
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bk_adder_scheduler.sv
// Time-shares one external combinational Brent-Kung adder between NREQ
// requesters. BK_SCHED_WIDE_EN enables two-pass double-width requests.
module bk_adder_scheduler
    import bk_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input logic                 clk,
    input logic                 rst_n,
    bk_adder_scheduler_if.slave bus
);

    localparam int IW = ID_W(NREQ);
`ifdef BK_SCHED_WIDE_EN
    localparam int OPW = 2 * WIDTH;
`else
    localparam int OPW = WIDTH;
`endif

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_id;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_cin;
    logic [OPW-1:0]   r_sum;
    logic             r_cout;
    logic             r_rsp_valid;
`ifdef BK_SCHED_WIDE_EN
    logic             r_wide;
    logic [WIDTH-1:0] r_a_hi;
    logic [WIDTH-1:0] r_b_hi;
`endif

    logic [NREQ-1:0]  w_grant;
    logic [IW-1:0]    w_gid;
    logic             w_any;
    logic [OPW-1:0]   w_sel_a;
    logic [OPW-1:0]   w_sel_b;

    bk_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_valid (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_id    (w_gid),
        .o_any   (w_any)
    );

    assign w_sel_a = bus.req_a[w_gid*OPW +: OPW];
    assign w_sel_b = bus.req_b[w_gid*OPW +: OPW];

    // Gated by rst_n so the accept strobe drops the moment reset asserts.
    assign bus.req_ready = (r_state == S_IDLE && rst_n) ? w_grant : '0;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
    assign bus.add_cin   = r_add_cin;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_cout  = r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_rsp_valid <= 1'b0;
`ifdef BK_SCHED_WIDE_EN
            r_wide      <= 1'b0;
            r_a_hi      <= '0;
            r_b_hi      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id      <= w_gid;
                        r_add_a   <= w_sel_a[WIDTH-1:0];
                        r_add_b   <= w_sel_b[WIDTH-1:0];
                        r_add_cin <= bus.req_cin[w_gid];
`ifdef BK_SCHED_WIDE_EN
                        r_wide    <= bus.req_wide[w_gid];
                        r_a_hi    <= w_sel_a[OPW-1:WIDTH];
                        r_b_hi    <= w_sel_b[OPW-1:WIDTH];
`endif
                        r_state   <= S_EXEC_LO;
                    end
                end
                S_EXEC_LO: begin
                    r_sum <= OPW'(bus.add_sum);
`ifdef BK_SCHED_WIDE_EN
                    if (r_wide) begin
                        // r_add_cin doubles as the carry register between passes.
                        r_add_a   <= r_a_hi;
                        r_add_b   <= r_b_hi;
                        r_add_cin <= bus.add_c[WIDTH-1];
                        r_state   <= S_EXEC_HI;
                    end else
`endif
                    begin
                        r_add_a     <= '0;
                        r_add_b     <= '0;
                        r_add_cin   <= 1'b0;
                        r_cout      <= bus.add_c[WIDTH-1];
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
`ifdef BK_SCHED_WIDE_EN
                S_EXEC_HI: begin
                    r_sum[OPW-1:WIDTH] <= bus.add_sum;
                    r_cout             <= bus.add_c[WIDTH-1];
                    r_add_a            <= '0;
                    r_add_b            <= '0;
                    r_add_cin          <= 1'b0;
                    r_rsp_valid        <= 1'b1;
                    r_state            <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= (r_id == IW'(NREQ - 1)) ? '0 : r_id + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
